// File: rtl/common_pkg.sv
// Shared types for the clock UI path: command pulses, UI modes and
// millisecond-to-tick conversion.
package common_pkg;

  typedef struct packed {
    logic set_time;
    logic set_alarm;
    logic toggle_alarm;
    logic left;
    logic up;
    logic display_time;
  } clock_op_t;

  typedef enum logic [1:0] {
    UI_DISPLAY   = 2'b00,
    UI_SET_TIME  = 2'b01,
    UI_SET_ALARM = 2'b10
  } ui_mode_t;

  typedef enum logic [1:0] {
    BP_IDLE  = 2'b00,
    BP_PRESS = 2'b01,
    BP_HELD  = 2'b10
  } bp_state_t;

  // A duration that rounds below one tick still takes one tick.
  function automatic int ms_to_ticks(input int ms, input int freq);
    longint t;
    t = (longint'(ms) * longint'(freq)) / 64'sd1000;
    return (t < 64'sd1) ? 1 : int'(t);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_press_detector.sv
// One push-button: 2-FF sync, debounce, arm-on-release, and the
// short / long / auto-repeat press classifier.
module button_press_detector
  import common_pkg::*;
#(
  parameter int DEBOUNCE_TICKS   = 1,
  parameter int LONG_PRESS_TICKS = 2,
  parameter int REPEAT_TICKS     = 1,
  parameter int BTN_ACTIVE_LOW   = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pressed,
  output logic o_short,
  output logic o_long,
  output logic o_repeat
);

  localparam int CW = $clog2(max3(DEBOUNCE_TICKS, LONG_PRESS_TICKS, REPEAT_TICKS) + 1);
  localparam logic PAD_PRESSED = (BTN_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);

  logic          sync1_q, sync2_q, sample;
  logic          deb_q, deb_d, armed_q, armed_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d, hold_q, hold_d, rep_q, rep_d;
  bp_state_t     st_q, st_d;

  // Sync and debounce start from "pressed" so a button held through reset
  // never produces the release that arms the detector.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q   <= PAD_PRESSED;
      sync2_q   <= PAD_PRESSED;
      deb_q     <= 1'b1;
      deb_cnt_q <= '0;
      armed_q   <= 1'b0;
      st_q      <= BP_IDLE;
      hold_q    <= '0;
      rep_q     <= '0;
    end else begin
      sync1_q   <= i_btn;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      armed_q   <= armed_d;
      st_q      <= st_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
    end
  end

  assign sample = (sync2_q == PAD_PRESSED);

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    armed_d   = armed_q;
    if (sample != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = sample;
        if (!sample) armed_d = 1'b1;
      end else begin
        deb_cnt_d = deb_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    st_d     = st_q;
    hold_d   = hold_q;
    rep_d    = rep_q;
    o_short  = 1'b0;
    o_long   = 1'b0;
    o_repeat = 1'b0;
    case (st_q)
      BP_IDLE: begin
        if (armed_q && deb_q) begin
          st_d   = BP_PRESS;
          hold_d = '0;
        end
      end
      BP_PRESS: begin
        if (!deb_q) begin
          o_short = 1'b1;
          st_d    = BP_IDLE;
        end else if (hold_q == LONG_LAST) begin
          o_long = 1'b1;
          st_d   = BP_HELD;
          rep_d  = '0;
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
      BP_HELD: begin
        if (!deb_q) begin
          st_d = BP_IDLE;
        end else if (rep_q == REP_LAST) begin
          o_repeat = 1'b1;
          rep_d    = '0;
        end else begin
          rep_d = rep_q + CW'(1);
        end
      end
      default: st_d = BP_IDLE;
    endcase
  end

  assign o_pressed = deb_q & armed_q;

endmodule

// File: rtl/clock_button_decoder.sv
// Two-button UI front end: per-button gestures plus UI mode become
// registered one-cycle clock_op_t command pulses.
module clock_button_decoder
  import common_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 2,
  parameter int DEBOUNCE_MS     = 20,
  parameter int LONG_PRESS_MS   = 1000,
  parameter int REPEAT_MS       = 200,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_btn_a,
  input  logic      i_btn_b,
  output clock_op_t o_clock_control,
  output ui_mode_t  o_mode
);

  localparam int DEB_T  = ms_to_ticks(DEBOUNCE_MS, CLOCK_FREQUENCY);
  localparam int LONG_T = ms_to_ticks(LONG_PRESS_MS, CLOCK_FREQUENCY);
  localparam int REP_T  = ms_to_ticks(REPEAT_MS, CLOCK_FREQUENCY);

  logic      a_p, a_short, a_long, a_rep;
  logic      b_p, b_short, b_long, b_rep;
  logic      chord_q, chord_d, both, a_evt, b_evt;
  clock_op_t op_q, op_d;
  ui_mode_t  mode_q, mode_d;

  button_press_detector #(
    .DEBOUNCE_TICKS(DEB_T), .LONG_PRESS_TICKS(LONG_T),
    .REPEAT_TICKS(REP_T), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
  ) u_btn_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_a),
    .o_pressed(a_p), .o_short(a_short), .o_long(a_long), .o_repeat(a_rep)
  );

  button_press_detector #(
    .DEBOUNCE_TICKS(DEB_T), .LONG_PRESS_TICKS(LONG_T),
    .REPEAT_TICKS(REP_T), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
  ) u_btn_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_b),
    .o_pressed(b_p), .o_short(b_short), .o_long(b_long), .o_repeat(b_rep)
  );

  assign both  = a_p & b_p;
  assign a_evt = a_short | a_long | a_rep;
  assign b_evt = b_short | b_long | b_rep;

  always_comb begin
    op_d    = '0;
    mode_d  = mode_q;
    chord_d = chord_q;
    if (both) begin
      chord_d = 1'b1;
    end else if (chord_q && !a_p && !b_p) begin
      chord_d          = 1'b0;
      op_d.display_time = 1'b1;
      mode_d           = UI_DISPLAY;
    end
    // Any A event takes the slot; a simultaneous B event is dropped.
    if (!(chord_q || both)) begin
      if (a_evt) begin
        if (mode_q == UI_DISPLAY) begin
          if (a_long) begin
            op_d.set_time = 1'b1;
            mode_d        = UI_SET_TIME;
          end
        end else if (a_short) begin
          op_d.left = 1'b1;
        end else if (a_long) begin
          op_d.display_time = 1'b1;
          mode_d            = UI_DISPLAY;
        end
      end else if (b_evt) begin
        if (mode_q == UI_DISPLAY) begin
          if (b_long) begin
            op_d.set_alarm = 1'b1;
            mode_d         = UI_SET_ALARM;
          end else if (b_short) begin
            op_d.toggle_alarm = 1'b1;
          end
        end else begin
          op_d.up = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q    <= '0;
      mode_q  <= UI_DISPLAY;
      chord_q <= 1'b0;
    end else begin
      op_q    <= op_d;
      mode_q  <= mode_d;
      chord_q <= chord_d;
    end
  end

  assign o_clock_control = op_q;
  assign o_mode          = mode_q;

endmodule

// File: tb/tb_clock_button_decoder.sv
// Bench for clock_button_decoder at 1 kHz: directed gestures with literal
// timing expectations, then random gestures against a gesture-level model.
module tb_clock_button_decoder;
  import common_pkg::*;

  localparam int D = 20;
  localparam int L = 1000;
  localparam int R = 200;

  logic      clk = 1'b0, rst = 1'b1, pad_a = 1'b1, pad_b = 1'b1;
  clock_op_t op;
  ui_mode_t  mode;

  clock_button_decoder #(
    .CLOCK_FREQUENCY(1000), .DEBOUNCE_MS(20), .LONG_PRESS_MS(1000),
    .REPEAT_MS(200), .BTN_ACTIVE_LOW(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_btn_a(pad_a), .i_btn_b(pad_b),
    .o_clock_control(op), .o_mode(mode)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  bit smp_a = 1'b1, smp_b = 1'b1, smp_rst = 1'b1;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    smp_a   <= pad_a;
    smp_b   <= pad_b;
    smp_rst <= rst;
  end

  // Gesture-level model: pad delayed two samples, level accepted after D equal
  // samples, gestures classified by time since the debounced press.
  bit        dl1[2], dl2[2], lvl[2], run_val[2], armed[2], holding[2];
  bit        ev_s[2], ev_l[2], ev_r[2];
  int        run[2], t_press[2], now;
  clock_op_t exp_op, nxt_op;
  ui_mode_t  exp_mode, nxt_mode;
  bit        chord, nxt_chord;

  int n_st, n_sa, n_tg, n_lf, n_up, n_dt, t_st, t_dt, t_up_first, t_up_last;

  task automatic model_reset();
    exp_op = '0; nxt_op = '0; exp_mode = UI_DISPLAY; nxt_mode = UI_DISPLAY;
    chord = 1'b0; nxt_chord = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dl1[i] = 1'b1; dl2[i] = 1'b1; lvl[i] = 1'b1; run_val[i] = 1'b1; run[i] = 0;
      armed[i] = 1'b0; holding[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit pin0, input bit pin1);
    bit p[2]; bit pr[2]; bit smp; bit sup; int d;
    p[0] = pin0; p[1] = pin1;
    exp_op = nxt_op; exp_mode = nxt_mode; chord = nxt_chord;
    now++;
    for (int i = 0; i < 2; i++) begin
      smp = dl2[i]; dl2[i] = dl1[i]; dl1[i] = p[i];
      if (smp == run_val[i]) run[i]++;
      else begin run_val[i] = smp; run[i] = 1; end
      if (run_val[i] != lvl[i] && run[i] >= D) begin
        lvl[i] = run_val[i];
        if (!lvl[i]) armed[i] = 1'b1;
        else if (armed[i]) begin holding[i] = 1'b1; t_press[i] = now; end
      end
      ev_s[i] = 1'b0; ev_l[i] = 1'b0; ev_r[i] = 1'b0;
      if (holding[i]) begin
        d = now - t_press[i];
        if (!lvl[i]) begin ev_s[i] = (d <= L); holding[i] = 1'b0; end
        else if (d == L) ev_l[i] = 1'b1;
        else if (d > L && ((d - L) % R) == 0) ev_r[i] = 1'b1;
      end
      pr[i] = lvl[i] & armed[i];
    end
    nxt_op = '0; nxt_mode = exp_mode; nxt_chord = chord;
    sup = chord || (pr[0] && pr[1]);
    if (pr[0] && pr[1]) nxt_chord = 1'b1;
    else if (chord && !pr[0] && !pr[1]) begin
      nxt_chord = 1'b0; nxt_op.display_time = 1'b1; nxt_mode = UI_DISPLAY;
    end
    if (!sup) begin
      if (ev_s[0] || ev_l[0] || ev_r[0]) begin
        if (exp_mode == UI_DISPLAY) begin
          if (ev_l[0]) begin nxt_op.set_time = 1'b1; nxt_mode = UI_SET_TIME; end
        end else if (ev_s[0]) nxt_op.left = 1'b1;
        else if (ev_l[0]) begin nxt_op.display_time = 1'b1; nxt_mode = UI_DISPLAY; end
      end else if (ev_s[1] || ev_l[1] || ev_r[1]) begin
        if (exp_mode == UI_DISPLAY) begin
          if (ev_l[1]) begin nxt_op.set_alarm = 1'b1; nxt_mode = UI_SET_ALARM; end
          else if (ev_s[1]) nxt_op.toggle_alarm = 1'b1;
        end else nxt_op.up = 1'b1;
      end
    end
  endtask

  task automatic clear_counts();
    n_st = 0; n_sa = 0; n_tg = 0; n_lf = 0; n_up = 0; n_dt = 0;
    t_st = -1; t_dt = -1; t_up_first = -1; t_up_last = -1;
  endtask

  // One clock: advance the model, compare every output, tally pulses.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rst || smp_rst) model_reset();
      else model_step(!smp_a, !smp_b);
      checks++;
      if (op !== exp_op || mode !== exp_mode) begin
        errors++;
        $display("FAIL cycle_model cyc=%0d op=%06b mode=%0d, expected op=%06b mode=%0d",
                 cyc, op, mode, exp_op, exp_mode);
      end
      if (op.set_time)     begin n_st++; t_st = cyc; end
      if (op.set_alarm)    n_sa++;
      if (op.toggle_alarm) n_tg++;
      if (op.left)         n_lf++;
      if (op.display_time) begin n_dt++; t_dt = cyc; end
      if (op.up) begin
        n_up++; t_up_last = cyc;
        if (t_up_first < 0) t_up_first = cyc;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  function automatic int total();
    return n_st + n_sa + n_tg + n_lf + n_up + n_dt;
  endfunction

  task automatic set_btn(input int b, input bit pressed);
    if (b == 0) pad_a = !pressed;
    else        pad_b = !pressed;
  endtask

  task automatic bouncy(input int b, input bit val);
    int nb;
    nb = int'($urandom_range(0, 3));
    for (int k = 0; k < nb; k++) begin
      set_btn(b, val);  tick(int'($urandom_range(1, 4)));
      set_btn(b, !val); tick(int'($urandom_range(1, 4)));
    end
    set_btn(b, val);
  endtask

  task automatic hold_btn(input int b, input int dur);
    bouncy(b, 1'b1); tick(dur); bouncy(b, 1'b0); tick(60);
  endtask

  initial begin
    int n, kind, b, dur, off;
    model_reset();
    now = 0;
    clear_counts();

    // 1: reset with A held; release after reset must stay silent
    pad_a = 1'b0;
    tick(4);
    chk("reset_op", int'(op), 0);
    chk("reset_mode", int'(mode), int'(UI_DISPLAY));
    rst = 1'b0;
    tick(50);
    pad_a = 1'b1;
    tick(100);
    chk("t1_no_pulse", total(), 0);
    chk("t1_mode", int'(mode), int'(UI_DISPLAY));

    // 2: bouncing A press held 1500 -> one set_time at stable press +1023
    clear_counts();
    for (int k = 0; k < 8; k++) begin pad_a = k[0]; tick(1); end
    pad_a = 1'b0; n = cyc;
    tick(1500);
    pad_a = 1'b1;
    tick(60);
    chk("t2_set_time_cnt", n_st, 1);
    chk("t2_set_time_at", t_st - n, 1023);
    chk("t2_total", total(), 1);
    chk("t2_mode", int'(mode), int'(UI_SET_TIME));

    // 3: short B in set-time -> one up, 23 cycles after the pad release
    clear_counts();
    pad_b = 1'b0; tick(300);
    pad_b = 1'b1; n = cyc;
    tick(60);
    chk("t3_up_cnt", n_up, 1);
    chk("t3_up_at", t_up_first - n, 23);
    chk("t3_total", total(), 1);

    // 4: B held 1650 -> up at +1023, +1223, +1423, +1623
    clear_counts();
    pad_b = 1'b0; n = cyc;
    tick(1650);
    pad_b = 1'b1;
    tick(60);
    chk("t4_up_cnt", n_up, 4);
    chk("t4_first_up", t_up_first - n, 1023);
    chk("t4_last_up", t_up_last - n, 1623);
    chk("t4_total", total(), 4);

    // back to display with A long
    clear_counts();
    pad_a = 1'b0; tick(1100); pad_a = 1'b1; tick(60);
    chk("ret_disp_cnt", n_dt, 1);
    chk("ret_mode", int'(mode), int'(UI_DISPLAY));

    // 5: B short toggles alarm; chord gives only display_time
    clear_counts();
    pad_b = 1'b0; tick(100); pad_b = 1'b1; tick(60);
    chk("t5_toggle", n_tg, 1);
    clear_counts();
    pad_a = 1'b0; pad_b = 1'b0;
    tick(1500);
    pad_a = 1'b1; pad_b = 1'b1; n = cyc;
    tick(60);
    chk("t5_no_set_time", n_st, 0);
    chk("t5_no_set_alarm", n_sa, 0);
    chk("t5_disp_cnt", n_dt, 1);
    chk("t5_disp_at", t_dt - n, 23);
    chk("t5_total", total(), 1);

    // 6: set-alarm, A long back to display, then reset mid B hold
    clear_counts();
    pad_b = 1'b0; tick(1100); pad_b = 1'b1; tick(60);
    chk("t6_set_alarm", n_sa, 1);
    chk("t6_mode_alarm", int'(mode), int'(UI_SET_ALARM));
    pad_a = 1'b0; tick(1100); pad_a = 1'b1; tick(60);
    chk("t6_disp", n_dt, 1);
    chk("t6_mode_disp", int'(mode), int'(UI_DISPLAY));
    pad_b = 1'b0; tick(1300);
    chk("t6_pre_rst_mode", int'(mode), int'(UI_SET_ALARM));
    rst = 1'b1;
    #1;
    chk("t6_rst_op", int'(op), 0);
    chk("t6_rst_mode", int'(mode), int'(UI_DISPLAY));
    tick(5);
    rst = 1'b0;
    clear_counts();
    tick(1500);
    pad_b = 1'b1;
    tick(60);
    chk("t6_held_silent", total(), 0);
    pad_b = 1'b0; tick(100); pad_b = 1'b1; tick(60);
    chk("t6_rearmed", n_tg, 1);

    // random gestures, checked cycle by cycle against the model
    for (int g = 0; g < 25; g++) begin
      kind = int'($urandom_range(0, 5));
      b    = int'($urandom_range(0, 1));
      case (kind)
        0: for (int k = 0; k < 4; k++) begin
             set_btn(b, 1'b1); tick(int'($urandom_range(1, 15)));
             set_btn(b, 1'b0); tick(int'($urandom_range(1, 10)));
           end
        1, 2: hold_btn(b, int'($urandom_range(30, 900)));
        3: begin
             dur = int'($urandom_range(1000, 1700));
             bouncy(b, 1'b1); tick(dur / 2);
             if ($urandom_range(0, 3) == 0) begin rst = 1'b1; tick(3); rst = 1'b0; end
             tick(dur / 2); bouncy(b, 1'b0); tick(60);
           end
        4: begin
             dur = int'($urandom_range(100, 1500));
             off = int'($urandom_range(0, 30));
             pad_a = 1'b0; pad_b = 1'b0; tick(dur);
             pad_a = 1'b1; tick(off); pad_b = 1'b1; tick(60);
           end
        default: begin
             dur = int'($urandom_range(50, 1200));
             off = int'($urandom_range(20, 400));
             pad_a = 1'b0; tick(off); pad_b = 1'b0; tick(dur);
             pad_a = 1'b1; tick(off); pad_b = 1'b1; tick(60);
           end
      endcase
      tick(int'($urandom_range(30, 100)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
